// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline definitions.
//   - datapath and register-index widths, REG_ZERO constant
//   - ALUOp width and encodings
//   - idex_t: the full ID/EX pipeline register contents
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_LUI = 4'd9
  } alu_op_e;

  // An all-zero idex_t is the pipeline bubble.
  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  sign_imm;
    logic [DATA_W-1:0]  pc_plus4;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
  } idex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: load-use hazard check bundle.
//   master: drives EX-stage load info, ID-stage source registers and flush;
//           receives stall.
//   slave : the comparator; receives the operands and drives stall.
interface id_ex_stage_if
  import mips_pkg::*;
();

  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             flush;
  logic             stall;

  modport master (
    output ex_mem_read, ex_rt, id_rs, id_rt, flush,
    input  stall
  );

  modport slave (
    input  ex_mem_read, ex_rt, id_rs, id_rt, flush,
    output stall
  );

endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: purely combinational load-use detector.
//   hz (slave modport): ex_mem_read/ex_rt from the ID/EX register,
//   id_rs/id_rt of the instruction in ID, flush; produces stall.
// A load into $zero never creates a dependency, and a flush squashes the
// dependent instruction anyway, so neither stalls.
module hazard_unit
  import mips_pkg::*;
(
  id_ex_stage_if.slave hz
);

  always_comb begin
    hz.stall = 1'b0;
    if (hz.ex_mem_read && (hz.ex_rt != REG_ZERO) && !hz.flush &&
        ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt))) begin
      hz.stall = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS ID/EX pipeline register with load-use stall detection.
//   Clk, reset             : clock, synchronous active-high reset
//   ReadData1/2            : register-file read data for Rs/Rt
//   id_*                   : decoded fields/controls of the instruction in ID
//   Flush                  : squash the instruction in ID (bubble into EX)
//   wb_RegWrite/WriteReg/WriteData : write-back register-file port
//   ex_*                   : registered copies of the id_* inputs and read data
//   Stall                  : combinational load-use stall (hold PC and IF/ID)
//   StallCount             : saturating count of inserted load-use bubbles
// Optional macro IDEX_WB_BYPASS_EN: forward the write-back value into the
// captured read data when it targets Rs/Rt in the same cycle.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  ReadData1,
  input  logic [DATA_W-1:0]  ReadData2,
  input  logic [REG_W-1:0]   id_Rs,
  input  logic [REG_W-1:0]   id_Rt,
  input  logic [REG_W-1:0]   id_Rd,
  input  logic [DATA_W-1:0]  id_SignImm,
  input  logic [DATA_W-1:0]  id_PCPlus4,
  input  logic               id_RegWrite,
  input  logic               id_MemtoReg,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_ALUSrc,
  input  logic               id_RegDst,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic               Flush,
  input  logic               wb_RegWrite,
  input  logic [REG_W-1:0]   wb_WriteReg,
  input  logic [DATA_W-1:0]  wb_WriteData,
  output logic [REG_W-1:0]   ex_Rs,
  output logic [REG_W-1:0]   ex_Rt,
  output logic [REG_W-1:0]   ex_Rd,
  output logic [DATA_W-1:0]  ex_SignImm,
  output logic [DATA_W-1:0]  ex_PCPlus4,
  output logic               ex_RegWrite,
  output logic               ex_MemtoReg,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_ALUSrc,
  output logic               ex_RegDst,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [DATA_W-1:0]  ex_ReadData1,
  output logic [DATA_W-1:0]  ex_ReadData2,
  output logic               Stall,
  output logic [15:0]        StallCount
);

  idex_t             ex_d, ex_q;
  logic [15:0]       stall_cnt_d, stall_cnt_q;
  logic [DATA_W-1:0] rd1_sel, rd2_sel;

  // Hazard detection uses the current ID/EX contents, not the next state.
  id_ex_stage_if hz_if ();

  assign hz_if.ex_mem_read = ex_q.mem_read;
  assign hz_if.ex_rt       = ex_q.rt;
  assign hz_if.id_rs       = id_Rs;
  assign hz_if.id_rt       = id_Rt;
  assign hz_if.flush       = Flush;

  hazard_unit u_hazard_unit (
    .hz (hz_if)
  );

  assign Stall = hz_if.stall;

`ifdef IDEX_WB_BYPASS_EN
  // The register file is written at the same edge this stage captures, so
  // take the write-back value directly for a matching non-zero register.
  always_comb begin
    rd1_sel = ReadData1;
    rd2_sel = ReadData2;
    if (wb_RegWrite && (wb_WriteReg != REG_ZERO)) begin
      if (wb_WriteReg == id_Rs) rd1_sel = wb_WriteData;
      if (wb_WriteReg == id_Rt) rd2_sel = wb_WriteData;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_RegWrite, wb_WriteReg, wb_WriteData};
  assign rd1_sel   = ReadData1;
  assign rd2_sel   = ReadData2;
`endif

  // Flush and Stall both load a bubble; Flush already masks Stall inside
  // the hazard unit, so a simultaneous pair yields exactly one bubble.
  always_comb begin
    ex_d = '0;
    if (!(Flush || Stall)) begin
      ex_d.reg_write  = id_RegWrite;
      ex_d.mem_to_reg = id_MemtoReg;
      ex_d.mem_read   = id_MemRead;
      ex_d.mem_write  = id_MemWrite;
      ex_d.alu_src    = id_ALUSrc;
      ex_d.reg_dst    = id_RegDst;
      ex_d.alu_op     = id_ALUOp;
      ex_d.rs         = id_Rs;
      ex_d.rt         = id_Rt;
      ex_d.rd         = id_Rd;
      ex_d.sign_imm   = id_SignImm;
      ex_d.pc_plus4   = id_PCPlus4;
      ex_d.read_data1 = rd1_sel;
      ex_d.read_data2 = rd2_sel;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_RegWrite  = ex_q.reg_write;
  assign ex_MemtoReg  = ex_q.mem_to_reg;
  assign ex_MemRead   = ex_q.mem_read;
  assign ex_MemWrite  = ex_q.mem_write;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_RegDst    = ex_q.reg_dst;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_Rs        = ex_q.rs;
  assign ex_Rt        = ex_q.rt;
  assign ex_Rd        = ex_q.rd;
  assign ex_SignImm   = ex_q.sign_imm;
  assign ex_PCPlus4   = ex_q.pc_plus4;
  assign ex_ReadData1 = ex_q.read_data1;
  assign ex_ReadData2 = ex_q.read_data2;
  assign StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed, scoreboard-based bench for id_ex_stage.
// Honours IDEX_WB_BYPASS_EN the same way as the design build.
module tb_id_ex_stage;
  import mips_pkg::*;

  typedef struct packed {
    logic        rw, mtr, mr, mw, as, rdst;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, pc, d1, d2;
  } mdl_t;

  typedef struct packed {
    mdl_t        ex;
    logic [15:0] cnt;
  } exp_t;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        Flush = 1'b0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_WriteReg = 5'd0;
  logic [31:0] wb_WriteData = 32'd0;
  mdl_t        id = '0;

  logic [4:0]  ex_Rs, ex_Rt, ex_Rd;
  logic [31:0] ex_SignImm, ex_PCPlus4, ex_ReadData1, ex_ReadData2;
  logic        ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_RegDst;
  logic [3:0]  ex_ALUOp;
  logic        Stall;
  logic [15:0] StallCount;

  mdl_t        mdl = '0;
  logic [15:0] cnt = 16'd0;
  logic        mdl_valid = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_0400;
  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 Clk = ~Clk;

  id_ex_stage dut (
    .Clk          (Clk),
    .reset        (reset),
    .ReadData1    (id.d1),
    .ReadData2    (id.d2),
    .id_Rs        (id.rs),
    .id_Rt        (id.rt),
    .id_Rd        (id.rd),
    .id_SignImm   (id.imm),
    .id_PCPlus4   (id.pc),
    .id_RegWrite  (id.rw),
    .id_MemtoReg  (id.mtr),
    .id_MemRead   (id.mr),
    .id_MemWrite  (id.mw),
    .id_ALUSrc    (id.as),
    .id_RegDst    (id.rdst),
    .id_ALUOp     (id.op),
    .Flush        (Flush),
    .wb_RegWrite  (wb_RegWrite),
    .wb_WriteReg  (wb_WriteReg),
    .wb_WriteData (wb_WriteData),
    .ex_Rs        (ex_Rs),
    .ex_Rt        (ex_Rt),
    .ex_Rd        (ex_Rd),
    .ex_SignImm   (ex_SignImm),
    .ex_PCPlus4   (ex_PCPlus4),
    .ex_RegWrite  (ex_RegWrite),
    .ex_MemtoReg  (ex_MemtoReg),
    .ex_MemRead   (ex_MemRead),
    .ex_MemWrite  (ex_MemWrite),
    .ex_ALUSrc    (ex_ALUSrc),
    .ex_RegDst    (ex_RegDst),
    .ex_ALUOp     (ex_ALUOp),
    .ex_ReadData1 (ex_ReadData1),
    .ex_ReadData2 (ex_ReadData2),
    .Stall        (Stall),
    .StallCount   (StallCount)
  );

  // Probe bundle: the bench's view of the hazard-check signals.
  id_ex_stage_if mon ();
  assign mon.ex_mem_read = ex_MemRead;
  assign mon.ex_rt       = ex_Rt;
  assign mon.id_rs       = id.rs;
  assign mon.id_rt       = id.rt;
  assign mon.flush       = Flush;
  assign mon.stall       = Stall;

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic [3:0] op,
                        input logic [31:0] d1, input logic [31:0] d2);
    pc_ctr  = pc_ctr + 32'd4;
    id.rs   = rs;
    id.rt   = rt;
    id.rd   = rd;
    id.mr   = mr;
    id.mw   = mw;
    id.op   = op;
    id.d1   = d1;
    id.d2   = d2;
    id.rw   = !mw;
    id.mtr  = mr;
    id.as   = mr | mw;
    id.rdst = !(mr | mw);
    id.imm  = {16'hFFFF, 3'b000, rd, 3'b101, rs};
    id.pc   = pc_ctr;
  endtask

  // One clock: predict, check Stall, push expectation, clock, pop and compare.
  task automatic tick(input string t);
    exp_t        e;
    logic        ms;
    logic [152:0] obs;
    #1;
    ms = mdl.mr && (mdl.rt != 5'd0) && ((mdl.rt == id.rs) || (mdl.rt == id.rt)) && !Flush;
    if (mdl_valid) begin
      vectors++;
      assert (mon.stall === ms) else begin
        miscompares++;
        $error("FAIL %s stall: observed %b expected %b", t, mon.stall, ms);
      end
    end
    if (reset) begin
      mdl = '0;
      cnt = 16'd0;
    end else begin
      if (ms && (cnt != 16'hFFFF)) cnt = cnt + 16'd1;
      if (Flush || ms) begin
        mdl = '0;
      end else begin
        mdl = id;
`ifdef IDEX_WB_BYPASS_EN
        if (wb_RegWrite && (wb_WriteReg != 5'd0) && (wb_WriteReg == id.rs)) mdl.d1 = wb_WriteData;
        if (wb_RegWrite && (wb_WriteReg != 5'd0) && (wb_WriteReg == id.rt)) mdl.d2 = wb_WriteData;
`endif
      end
    end
    mdl_valid = 1'b1;
    e.ex  = mdl;
    e.cnt = cnt;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e   = sb.pop_front();
    obs = {ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_RegDst,
           ex_ALUOp, ex_Rs, ex_Rt, ex_Rd, ex_SignImm, ex_PCPlus4, ex_ReadData1, ex_ReadData2};
    vectors++;
    assert (obs === e.ex) else begin
      miscompares++;
      $error("FAIL %s ex: observed %h expected %h", t, obs, e.ex);
    end
    vectors++;
    assert (StallCount === e.cnt) else begin
      miscompares++;
      $error("FAIL %s count: observed %h expected %h", t, StallCount, e.cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset
    set_id(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, ALU_ADD, 32'h1111_1111, 32'h2222_2222);
    reset = 1'b1;
    tick("reset0");
    tick("reset1");
    reset = 1'b0;

    // Plain captures with varied patterns
    set_id(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, ALU_ADD, 32'hDEAD_BEEF, 32'h0123_4567);
    tick("cap_add");
    set_id(5'd31, 5'd30, 5'd29, 1'b0, 1'b1, ALU_OR, 32'hFFFF_FFFF, 32'h8000_0001);
    tick("cap_store");
    set_id(5'd4, 5'd5, 5'd6, 1'b0, 1'b0, ALU_SLT, 32'h0, 32'h5A5A_A5A5);
    tick("cap_slt");

    // Load-use on Rs: one stall, bubble, count 0->1, then capture
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h100, 32'h0);
    tick("lw_rt8");
    set_id(5'd8, 5'd3, 5'd10, 1'b0, 1'b0, ALU_SUB, 32'hAAAA_0000, 32'h0000_5555);
    tick("hz_rs_stall");
    tick("hz_rs_capture");

    // Load-use on Rt
    set_id(5'd2, 5'd12, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h200, 32'h0);
    tick("lw_rt12");
    set_id(5'd7, 5'd12, 5'd13, 1'b0, 1'b0, ALU_AND, 32'h7, 32'hC);
    tick("hz_rt_stall");
    tick("hz_rt_capture");

    // Hazard with Flush: bubble, no stall, count unchanged
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h300, 32'h0);
    tick("lw_rt8_b");
    set_id(5'd8, 5'd8, 5'd9, 1'b0, 1'b0, ALU_XOR, 32'h9, 32'h9);
    Flush = 1'b1;
    tick("hz_flush");
    Flush = 1'b0;
    set_id(5'd11, 5'd12, 5'd13, 1'b0, 1'b0, ALU_NOR, 32'hB, 32'hC);
    tick("post_flush");

    // Load into $zero: no stall
    set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h400, 32'h0);
    tick("lw_rt0");
    set_id(5'd0, 5'd0, 5'd14, 1'b0, 1'b0, ALU_ADD, 32'h1, 32'h2);
    tick("hz_r0");

    // Near-miss indices (differ by one bit): no stall
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h500, 32'h0);
    tick("lw_rt8_c");
    set_id(5'd24, 5'd9, 5'd15, 1'b0, 1'b0, ALU_SRL, 32'h18, 32'h9);
    tick("near_miss");

    // Write-back bypass on Rt, then a $zero write that must not forward
    wb_RegWrite  = 1'b1;
    wb_WriteReg  = 5'd9;
    wb_WriteData = 32'h0000_00AA;
    set_id(5'd3, 5'd9, 5'd16, 1'b0, 1'b0, ALU_ADD, 32'h3, 32'h2);
    tick("wb_rt9");
    set_id(5'd9, 5'd4, 5'd17, 1'b0, 1'b0, ALU_ADD, 32'h5, 32'h6);
    tick("wb_rs9");
    wb_WriteReg  = 5'd0;
    set_id(5'd0, 5'd0, 5'd18, 1'b0, 1'b0, ALU_LUI, 32'h7, 32'h8);
    tick("wb_r0");
    wb_RegWrite  = 1'b0;
    wb_WriteReg  = 5'd9;
    set_id(5'd9, 5'd9, 5'd19, 1'b0, 1'b0, ALU_SLL, 32'hC0, 32'hC1);
    tick("wb_off");
    wb_WriteReg  = 5'd0;

    // Saturation: preload 16'hFFFE and force three load-use stalls
    @(negedge Clk);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h600 + 32'(i), 32'h0);
      tick("sat_lw");
      set_id(5'd8, 5'd2, 5'd20, 1'b0, 1'b0, ALU_SUB, 32'h700 + 32'(i), 32'h1);
      tick("sat_stall");
      tick("sat_capture");
    end

    // Reset while stalling: everything clears, no stall afterwards
    set_id(5'd1, 5'd8, 5'd0, 1'b1, 1'b0, ALU_ADD, 32'h800, 32'h0);
    tick("lw_rt8_d");
    set_id(5'd8, 5'd5, 5'd21, 1'b0, 1'b0, ALU_OR, 32'h801, 32'h802);
    reset = 1'b1;
    tick("rst_mid_stall");
    reset = 1'b0;
    tick("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port Clk, input, 1, sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on posedge Clk.
REQ-003 SHALL have inputs ReadData1/ReadData2, 32 each, register-file read data for Rs/Rt.
REQ-004 SHALL have inputs id_Rs/id_Rt/id_Rd, 5 each, and id_SignImm and id_PCPlus4, 32 each.
REQ-005 SHALL have control inputs id_RegWrite, id_MemtoReg, id_MemRead, id_MemWrite, id_ALUSrc and id_RegDst (1 each), plus id_ALUOp (4).
REQ-006 SHALL have input Flush, 1, branch/jump squash of the instruction currently in ID.
REQ-007 SHALL have inputs wb_RegWrite (1), wb_WriteReg (5) and wb_WriteData (32), the write-back stage's register-file write port.
REQ-008 SHALL have outputs ex_* as registered copies of every id_* input plus ex_ReadData1/ex_ReadData2, widths as inputs.
REQ-009 SHALL have output Stall, 1, combinational; holds PC and IF/ID when high.
REQ-010 SHALL have output StallCount, 16, registered count of inserted load-use bubbles.

Function
REQ-011 Stall SHALL equal ex_MemRead AND ex_Rt!=0 AND (ex_Rt==id_Rs OR ex_Rt==id_Rt) AND NOT Flush, using current register contents.
REQ-012 When Flush or Stall is high at posedge, the stage SHALL load a bubble: all ex_ control outputs 0, ex_ALUOp 0, all other ex_ outputs 0.
REQ-013 Otherwise, the stage SHALL capture every id_ input into its ex_ counterpart at posedge; latency is exactly 1 cycle.
REQ-014 Flush SHALL have priority over Stall; a simultaneous hazard and Flush SHALL produce one bubble, Stall=0, and no StallCount increment.
REQ-015 A bubble SHALL never cause Stall on the following cycle, since its ex_MemRead is 0, so a single load-use SHALL stall for exactly one cycle.
REQ-016 StallCount SHALL increment by 1 on each posedge where Stall=1 and saturate at 16'hFFFF with no wrap.
REQ-017 A hazard on register 0 (ex_Rt==0) SHALL NOT stall.
REQ-018 Each 5-bit register comparison SHALL be exact equality; no partial-field matching.

Reset
REQ-019 On posedge Clk with reset=1, all ex_ outputs and StallCount SHALL clear to 0, with reset taking priority over Flush and Stall.
REQ-020 Stall SHALL read 0 in the cycle after reset because ex_MemRead is 0; reset mid-stall SHALL discard the pending instruction and leave no bubble debt.

Configuration
REQ-021 With IDEX_WB_BYPASS_EN defined, the stage SHALL substitute wb_WriteData for a captured ReadData1 (or ReadData2) when wb_RegWrite=1, wb_WriteReg!=0 and wb_WriteReg==id_Rs (or id_Rt).
REQ-022 Without IDEX_WB_BYPASS_EN, ReadData1/ReadData2 SHALL be captured unmodified, and the wb_ ports SHALL be present but unused.

Structure
REQ-023 A shared package mips_pkg SHALL hold the ALUOp width/encodings, the register-index width (5), the data width (32) and the REG_ZERO constant.
REQ-024 Load-use detection SHALL be a sub-module named hazard_unit (pure comparator producing Stall); all registers SHALL live in id_ex_stage.

Verification
REQ-025 Scenario: ex_MemRead=1, ex_Rt=8; drive id_Rs=8 -> Stall=1 for one cycle, next ex_ controls all 0, StallCount 0->1, instruction captured the cycle after.
REQ-026 Scenario: same hazard with Flush=1 -> Stall=0, bubble loaded, StallCount unchanged.
REQ-027 Scenario: ex_MemRead=1, ex_Rt=0, id_Rs=0 -> Stall=0, normal capture.
REQ-028 Scenario (bypass on): wb_RegWrite=1, wb_WriteReg=9, wb_WriteData=32'h0000_00AA, id_Rt=9, ReadData2=32'h2 -> ex_ReadData2=32'hAA; with bypass off -> 32'h2.
REQ-029 Scenario: preload StallCount=16'hFFFE, force 3 consecutive load-use stalls -> StallCount ends at 16'hFFFF.
REQ-030 Scenario: assert reset during Stall=1 -> all ex_ outputs 0 and StallCount 0 after posedge, Stall=0 next cycle.
